mips_control_fsm: RTL and testbench

Multicycle control unit for the MIPS datapath. It sequences the PC register, memory port, instruction register, register file and ALU through fetch/decode/execute/memory/writeback, and waits a configurable number of cycles on memory reads. It traps on illegal instructions and arithmetic overflow. It sits beside the `control` top level and drives its PC write enable and every datapath mux select.

---
 rtl/control_pkg.sv | 66 ++++++
 rtl/alu_decoder.sv | 20 ++
 rtl/mips_control_fsm.sv | 184 ++++++++++++++++++
 tb/tb_mips_control_fsm.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// control_pkg: shared state, opcode/funct, ALUOp, mux-select and trap-cause encodings
package control_pkg;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_FETCH_WAIT,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_READ_WAIT,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXEC_R,
        S_R_WB,
        S_EXEC_I,
        S_I_WB,
        S_BRANCH,
        S_JUMP,
        S_TRAP
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_XOR = 6'h26;
    localparam logic [5:0] F_SLT = 6'h2A;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b110;
    localparam logic [2:0] ALU_CMP  = 3'b111;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MDR = 2'b01;
    localparam logic [1:0] MTR_LT  = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_OVF     = 2'b10;

    // Only signed add/sub R-type ops can raise an overflow trap
    function automatic logic is_add_sub(input logic [5:0] f);
        return (f == F_ADD) || (f == F_SUB);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps an R-type funct field to an ALUOp and flags unsupported functs
module alu_decoder
    import control_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_op,
    output logic       o_valid
);

    // Priority-free lookup; unknown functs yield ALU_NONE with valid low
    always_comb begin
        o_alu_op = (i_funct == F_ADD) ? ALU_ADD :
                   (i_funct == F_SUB) ? ALU_SUB :
                   (i_funct == F_AND) ? ALU_AND :
                   (i_funct == F_XOR) ? ALU_XOR :
                   (i_funct == F_SLT) ? ALU_CMP : ALU_NONE;
        o_valid  = (o_alu_op != ALU_NONE);
    end

endmodule

// File: rtl/mips_control_fsm.sv
// mips_control_fsm: multicycle MIPS control unit with memory wait states and traps
module mips_control_fsm
    import control_pkg::*;
#(
    parameter int MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MDRWrite,
    output logic       ABWrite,
    output logic       ALUOutWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       trap,
    output logic [1:0] cause
);

    localparam int W_CNT = $clog2(MEM_WAIT + 1);

    state_t             r_state;
    state_t             w_next;
    logic   [W_CNT-1:0] r_cnt;
    logic   [1:0]       r_cause;
    logic   [1:0]       w_cause;
    logic   [2:0]       w_alu_op;
    logic               w_valid;
    logic               w_wait;
    logic               w_last;

    alu_decoder u_alu_decoder (
        .i_funct (funct),
        .o_alu_op(w_alu_op),
        .o_valid (w_valid)
    );

    assign w_wait = (r_state == S_FETCH_WAIT) || (r_state == S_MEM_READ_WAIT);
    assign w_last = (r_cnt == W_CNT'(1));
    assign cause  = r_cause;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_RESET;
        else     r_state <= w_next;
    end

    // Wait counter loads as a wait state is entered and counts down to 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                              r_cnt <= '0;
        else if (r_state == S_FETCH || r_state == S_MEM_READ) r_cnt <= W_CNT'(MEM_WAIT);
        else if (w_wait && !w_last)                           r_cnt <= r_cnt - 1'b1;
    end

    // Trap cause, latched on the transition into TRAP and held until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cause <= CAUSE_NONE;
        else     r_cause <= w_cause;
    end

    // Next-state and datapath controls; everything defaults to 0
    always_comb begin
        w_next      = r_state;
        w_cause     = r_cause;
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MDRWrite    = 1'b0;
        ABWrite     = 1'b0;
        ALUOutWrite = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = MTR_ALU;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALU_NONE;
        PCSource    = PCS_ALU;
        trap        = 1'b0;
        case (r_state)
            S_RESET: w_next = S_FETCH;
            S_FETCH: w_next = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                if (w_last) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    ALUSrcB = SRCB_4;
                    ALUOp   = ALU_ADD;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                ABWrite     = 1'b1;
                ALUOutWrite = 1'b1;
                ALUSrcB     = SRCB_IMM_SH;
                ALUOp       = ALU_ADD;
                w_next      = (opcode == OP_LW || opcode == OP_SW)  ? S_MEM_ADDR :
                              (opcode == OP_R)                      ? S_EXEC_R   :
                              (opcode == OP_ADDI)                   ? S_EXEC_I   :
                              (opcode == OP_BEQ || opcode == OP_BNE) ? S_BRANCH  :
                              (opcode == OP_J)                      ? S_JUMP     : S_TRAP;
                w_cause     = (w_next == S_TRAP) ? CAUSE_ILLEGAL : r_cause;
            end
            S_MEM_ADDR: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_IMM;
                ALUOp       = ALU_ADD;
                ALUOutWrite = 1'b1;
                w_next      = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                IorD   = 1'b1;
                w_next = S_MEM_READ_WAIT;
            end
            S_MEM_READ_WAIT: begin
                IorD     = 1'b1;
                MDRWrite = w_last;
                w_next   = w_last ? S_MEM_WB : S_MEM_READ_WAIT;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = MTR_MDR;
                w_next   = S_FETCH;
            end
            S_MEM_WRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_EXEC_R: begin
                ALUSrcA     = 1'b1;
                ALUOutWrite = 1'b1;
                ALUOp       = w_alu_op;
                w_next      = (!w_valid || (overflow && is_add_sub(funct))) ? S_TRAP : S_R_WB;
                w_cause     = !w_valid ? CAUSE_ILLEGAL :
                              (overflow && is_add_sub(funct)) ? CAUSE_OVF : r_cause;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                MemtoReg = (funct == F_SLT) ? MTR_LT : MTR_ALU;
                w_next   = S_FETCH;
            end
            S_EXEC_I: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_IMM;
                ALUOp       = ALU_ADD;
                ALUOutWrite = 1'b1;
                w_next      = overflow ? S_TRAP : S_I_WB;
                w_cause     = overflow ? CAUSE_OVF : r_cause;
            end
            S_I_WB: begin
                RegWrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALU_SUB;
                PCSource = PCS_ALUOUT;
                PCWrite  = (opcode == OP_BEQ) ? zero : ~zero;
                w_next   = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCS_JUMP;
                w_next   = S_FETCH;
            end
            S_TRAP: trap = 1'b1;
            default: w_next = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_mips_control_fsm.sv
// tb_mips_control_fsm: directed checks of two control FSMs (MEM_WAIT=1 and MEM_WAIT=3)
module tb_mips_control_fsm;

    // Output vector layout: {PCWrite,IorD,MemWrite,IRWrite,MDRWrite,ABWrite,ALUOutWrite,
    //                        RegWrite,RegDst,MemtoReg[1:0],ALUSrcA,ALUSrcB[1:0],ALUOp[2:0],
    //                        PCSource[1:0],trap,cause[1:0]}
    localparam logic [21:0] PCW      = 22'h200000;
    localparam logic [21:0] IORD     = 22'h100000;
    localparam logic [21:0] MEMW     = 22'h080000;
    localparam logic [21:0] IRW      = 22'h040000;
    localparam logic [21:0] MDRW     = 22'h020000;
    localparam logic [21:0] ABW      = 22'h010000;
    localparam logic [21:0] ALUOW    = 22'h008000;
    localparam logic [21:0] REGW     = 22'h004000;
    localparam logic [21:0] REGD     = 22'h002000;
    localparam logic [21:0] M_MDR    = 22'h000800;
    localparam logic [21:0] M_LT     = 22'h001000;
    localparam logic [21:0] SRCA     = 22'h000400;
    localparam logic [21:0] SB_4     = 22'h000100;
    localparam logic [21:0] SB_IMM   = 22'h000200;
    localparam logic [21:0] SB_SH    = 22'h000300;
    localparam logic [21:0] A_ADD    = 22'h000020;
    localparam logic [21:0] A_SUB    = 22'h000040;
    localparam logic [21:0] A_AND    = 22'h000060;
    localparam logic [21:0] A_XOR    = 22'h0000C0;
    localparam logic [21:0] A_CMP    = 22'h0000E0;
    localparam logic [21:0] P_OUT    = 22'h000008;
    localparam logic [21:0] P_J      = 22'h000010;
    localparam logic [21:0] TRP      = 22'h000004;
    localparam logic [21:0] C_ILL    = 22'h000001;
    localparam logic [21:0] C_OVF    = 22'h000002;
    localparam logic [21:0] NONE     = 22'h000000;

    localparam logic [21:0] E_FWL  = PCW | IRW | SB_4 | A_ADD;
    localparam logic [21:0] E_DEC  = ABW | ALUOW | SB_SH | A_ADD;
    localparam logic [21:0] E_MADR = SRCA | SB_IMM | A_ADD | ALUOW;
    localparam logic [21:0] E_BR   = SRCA | A_SUB | P_OUT;

    // Full lw instruction with MEM_WAIT=3, one entry per cycle after FETCH, ending on the next FETCH
    localparam logic [21:0] LW_EXP [11] = '{NONE, NONE, E_FWL, E_DEC, E_MADR,
                                            IORD, IORD, IORD, IORD | MDRW,
                                            REGW | M_MDR, NONE};

    logic       clk = 1'b0;
    logic       rst1, rst3, zero, overflow;
    logic [5:0] opcode, funct;

    logic       p1, i1, mw1, ir1, md1, ab1, ao1, rw1, rd1, sa1, tr1;
    logic [1:0] mt1, sb1, ps1, ca1;
    logic [2:0] op1;
    logic       p3, i3, mw3, ir3, md3, ab3, ao3, rw3, rd3, sa3, tr3;
    logic [1:0] mt3, sb3, ps3, ca3;
    logic [2:0] op3;
    logic [21:0] o1, o3, acc;

    int checks = 0;
    int errors = 0;
    int mdr_cnt;

    assign o1 = {p1, i1, mw1, ir1, md1, ab1, ao1, rw1, rd1, mt1, sa1, sb1, op1, ps1, tr1, ca1};
    assign o3 = {p3, i3, mw3, ir3, md3, ab3, ao3, rw3, rd3, mt3, sa3, sb3, op3, ps3, tr3, ca3};

    always #5 clk = ~clk;

    mips_control_fsm #(.MEM_WAIT(1)) dut1 (
        .clk(clk), .rst(rst1), .opcode(opcode), .funct(funct), .zero(zero), .overflow(overflow),
        .PCWrite(p1), .IorD(i1), .MemWrite(mw1), .IRWrite(ir1), .MDRWrite(md1), .ABWrite(ab1),
        .ALUOutWrite(ao1), .RegWrite(rw1), .RegDst(rd1), .MemtoReg(mt1), .ALUSrcA(sa1),
        .ALUSrcB(sb1), .ALUOp(op1), .PCSource(ps1), .trap(tr1), .cause(ca1)
    );

    mips_control_fsm #(.MEM_WAIT(3)) dut3 (
        .clk(clk), .rst(rst3), .opcode(opcode), .funct(funct), .zero(zero), .overflow(overflow),
        .PCWrite(p3), .IorD(i3), .MemWrite(mw3), .IRWrite(ir3), .MDRWrite(md3), .ABWrite(ab3),
        .ALUOutWrite(ao3), .RegWrite(rw3), .RegDst(rd3), .MemtoReg(mt3), .ALUSrcA(sa3),
        .ALUSrcB(sb3), .ALUOp(op3), .PCSource(ps3), .trap(tr3), .cause(ca3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [21:0] got, input logic [21:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chki(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // From FETCH on dut1: FETCH_WAIT (final) then DECODE
    task automatic fd1(input string tag);
        step(); chk({tag, "_fw"}, o1, E_FWL);
        step(); chk({tag, "_dec"}, o1, E_DEC);
    endtask

    // From FETCH on dut3: three FETCH_WAIT cycles then DECODE
    task automatic fd3(input string tag);
        step(); chk({tag, "_fw1"}, o3, NONE);
        step(); chk({tag, "_fw2"}, o3, NONE);
        step(); chk({tag, "_fw3"}, o3, E_FWL);
        step(); chk({tag, "_dec"}, o3, E_DEC);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst1 = 1'b1; rst3 = 1'b1;
        opcode = 6'h00; funct = 6'h20; zero = 1'b0; overflow = 1'b0;
        step(); step();
        chk("reset_d1", o1, NONE);
        chk("reset_d3", o3, NONE);

        // dut1, MEM_WAIT=1: add
        rst1 = 1'b0;
        step(); chk("d1_first_fetch", o1, NONE);
        fd1("add");
        step(); chk("add_exec", o1, SRCA | ALUOW | A_ADD);
        step(); chk("add_wb", o1, REGW | REGD);
        step(); chk("add_next_fetch", o1, NONE);

        // slt and and, overflow must be ignored
        funct = 6'h2A; overflow = 1'b1;
        fd1("slt");
        step(); chk("slt_exec", o1, SRCA | ALUOW | A_CMP);
        step(); chk("slt_wb", o1, REGW | REGD | M_LT);
        step(); chk("slt_fetch", o1, NONE);
        funct = 6'h24;
        fd1("and");
        step(); chk("and_exec", o1, SRCA | ALUOW | A_AND);
        step(); chk("and_wb", o1, REGW | REGD);
        overflow = 1'b0;
        step(); chk("and_fetch", o1, NONE);

        // beq / bne resolve combinationally in BRANCH
        opcode = 6'h04; zero = 1'b1;
        fd1("beq");
        step(); chk("beq_taken", o1, E_BR | PCW);
        zero = 1'b0; #1 chk("beq_not_taken", o1, E_BR);
        opcode = 6'h05; #1 chk("bne_taken", o1, E_BR | PCW);
        zero = 1'b1; #1 chk("bne_not_taken", o1, E_BR);
        step(); chk("branch_fetch", o1, NONE);

        // jump
        opcode = 6'h02;
        fd1("j");
        step(); chk("jump", o1, PCW | P_J);
        step(); chk("jump_fetch", o1, NONE);

        // addi without then with overflow
        opcode = 6'h08;
        fd1("addi");
        step(); chk("addi_exec", o1, E_MADR);
        step(); chk("addi_wb", o1, REGW);
        step(); chk("addi_fetch", o1, NONE);
        overflow = 1'b1;
        fd1("addi_ovf");
        step(); chk("addi_ovf_exec", o1, E_MADR);
        step(); chk("addi_ovf_trap", o1, TRP | C_OVF);
        acc = '0;
        repeat (4) begin step(); acc |= o1; end
        chk("addi_ovf_trap_hold", acc, TRP | C_OVF);

        // reset leaves TRAP at once; then illegal opcode
        rst1 = 1'b1; overflow = 1'b0; opcode = 6'h3F;
        #1 chk("trap_async_reset", o1, NONE);
        step(); rst1 = 1'b0;
        step(); chk("illegal_fetch", o1, NONE);
        fd1("illegal");
        step(); chk("illegal_trap", o1, TRP | C_ILL);
        acc = '0;
        repeat (5) begin step(); acc |= o1; end
        chk("illegal_trap_hold", acc, TRP | C_ILL);
        rst1 = 1'b1;

        // dut3, MEM_WAIT=3: reset during the final FETCH_WAIT cycle
        rst3 = 1'b0;
        step(); chk("d3_fetch", o3, NONE);
        step(); chk("d3_fw1", o3, NONE);
        step(); chk("d3_fw2", o3, NONE);
        step(); chk("d3_fw3", o3, E_FWL);
        rst3 = 1'b1;
        #1 chk("mid_fetch_reset", o3, NONE);
        step(); chk("mid_fetch_reset_held", o3, NONE);
        rst3 = 1'b0; opcode = 6'h2B;
        step(); chk("refetch", o3, NONE);

        // sw
        fd3("sw");
        step(); chk("sw_addr", o3, E_MADR);
        step(); chk("sw_write", o3, IORD | MEMW);
        step(); chk("sw_fetch", o3, NONE);

        // lw, cycle by cycle
        opcode = 6'h23; mdr_cnt = 0;
        for (int k = 0; k < 11; k++) begin
            step();
            if (md3) mdr_cnt++;
            chk($sformatf("lw_cycle%0d", k + 1), o3, LW_EXP[k]);
        end
        chki("lw_mdr_count", mdr_cnt, 1);

        // xor with overflow ignored
        opcode = 6'h00; funct = 6'h26; overflow = 1'b1;
        fd3("xor");
        step(); chk("xor_exec", o3, SRCA | ALUOW | A_XOR);
        step(); chk("xor_wb", o3, REGW | REGD);
        step(); chk("xor_fetch", o3, NONE);

        // sub overflow
        funct = 6'h22;
        fd3("sub_ovf");
        step(); chk("sub_ovf_exec", o3, SRCA | ALUOW | A_SUB);
        step(); chk("sub_ovf_trap", o3, TRP | C_OVF);

        // illegal funct
        rst3 = 1'b1; overflow = 1'b0; funct = 6'h3F;
        step(); rst3 = 1'b0;
        step(); chk("badfunct_fetch", o3, NONE);
        fd3("badfunct");
        step(); chk("badfunct_exec", o3, SRCA | ALUOW);
        step(); chk("badfunct_trap", o3, TRP | C_ILL);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
